// File: rtl/metro_pkg.sv
// Shared definitions for the metro card receiver and its turnstile neighbour.
// The receiver's parity feature is selected with the CARDRX_PARITY_EN macro.
package metro_pkg;

  localparam int CODE_W_DEFAULT = 4;

  // Turnstile valid-code window, enforced downstream and reused by benches.
  localparam int CODE_MIN = 4;
  localparam int CODE_MAX = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    HOLD   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/metro_rx_timeout.sv
// Saturating idle-cycle counter for the card receiver; 'expired' is high for
// the single cycle in which the TIMEOUT_CYCLES-th strobe-free cycle occurs.
module metro_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up to saturation while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign expired = en && !clr && (cnt_q == CNT_FIRE);

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/metro_card_reader_rx.sv
// Serial card-frame receiver feeding the turnstile FSM: start, MSB-first data,
// optional even parity (CARDRX_PARITY_EN), stop; holds the code while busy.
module metro_card_reader_rx
  import metro_pkg::*;
#(
  parameter int CODE_W         = CODE_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              card_bit,
  input  logic              card_strobe,
  input  logic              downstream_busy,
  output logic [CODE_W-1:0] access_code,
  output logic              validate_code,
  output logic              frame_error,
  output logic              rx_busy
);

  localparam int BIT_CNT_W = $clog2(CODE_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(CODE_W - 1);

  rx_state_e             state_q, state_d;
  logic [CODE_W-1:0]     shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CODE_W-1:0]     access_code_q, access_code_d;
  logic                  validate_q, validate_d;
  logic                  frame_error_q, frame_error_d;
  logic                  rx_busy_q, rx_busy_d;
  logic                  frame_bad;
  logic                  timer_en;
  logic                  timer_clr;
  logic                  timer_expired;

`ifdef CARDRX_PARITY_EN
  logic                  parity_err_q, parity_err_d;

  function automatic logic even_parity(input logic [CODE_W-1:0] data);
    return ^data;
  endfunction
`endif

  // The timer only measures gaps inside a frame; outside it is held cleared.
  assign timer_en  = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
  assign timer_clr = card_strobe || !timer_en;

  metro_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (timer_en),
    .clr    (timer_clr),
    .expired(timer_expired)
  );

`ifdef CARDRX_PARITY_EN
  assign frame_bad = !card_bit || parity_err_q;
`else
  assign frame_bad = !card_bit;
`endif

  // Next-state and registered-output logic; a strobe always beats a timeout.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    access_code_d = access_code_q;
    validate_d    = 1'b0;
    frame_error_d = 1'b0;
`ifdef CARDRX_PARITY_EN
    parity_err_d  = parity_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (card_strobe && !card_bit) begin
          state_d   = DATA;
          bit_cnt_d = '0;
`ifdef CARDRX_PARITY_EN
          parity_err_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (card_strobe) begin
          shift_d   = {shift_q[CODE_W-2:0], card_bit};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef CARDRX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            state_d = DATA;
          end
        end else if (timer_expired) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = DATA;
        end
      end
`ifdef CARDRX_PARITY_EN
      PARITY: begin
        if (card_strobe) begin
          parity_err_d = (card_bit != even_parity(shift_q));
          state_d      = STOP;
        end else if (timer_expired) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (card_strobe) begin
          if (frame_bad) begin
            frame_error_d = 1'b1;
            state_d       = IDLE;
          end else if (!downstream_busy) begin
            access_code_d = shift_q;
            validate_d    = 1'b1;
            state_d       = IDLE;
          end else begin
            state_d = HOLD;
          end
        end else if (timer_expired) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      HOLD: begin
        if (!downstream_busy) begin
          access_code_d = shift_q;
          validate_d    = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rx_busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      access_code_q <= '0;
      validate_q    <= 1'b0;
      frame_error_q <= 1'b0;
      rx_busy_q     <= 1'b0;
`ifdef CARDRX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      access_code_q <= access_code_d;
      validate_q    <= validate_d;
      frame_error_q <= frame_error_d;
      rx_busy_q     <= rx_busy_d;
`ifdef CARDRX_PARITY_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign access_code   = access_code_q;
  assign validate_code = validate_q;
  assign frame_error   = frame_error_q;
  assign rx_busy       = rx_busy_q;

endmodule
